// File: rtl/string_pkg.sv
// Shared encodings and character-class helper for the string arbiter slice.
package string_pkg;

    typedef enum logic [1:0] {StIdle, StClear, StStream, StReport} ctl_state_e;
    typedef enum logic [1:0] {MStart, MDig, MSep, MDead} match_state_e;

    localparam logic [7:0] DIGIT_LO = 8'h30;
    localparam logic [7:0] DIGIT_HI = 8'h39;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= DIGIT_LO) && (c <= DIGIT_HI);
    endfunction

endpackage

// File: rtl/digit_alt_matcher.sv
// Recognises strings of single digits separated by single non-digits, e.g. "1a2".
module digit_alt_matcher
    import string_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       clear,
    input  logic       step,
    input  logic [7:0] ch,
    output logic       accept
);

    match_state_e st_q, st_d;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            st_q <= MStart;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        if (clear) begin
            st_d = MStart;
        end else if (step) begin
            unique case (st_q)
                MStart:  st_d = is_digit(ch) ? MDig : MDead;
                MDig:    st_d = is_digit(ch) ? MDead : MSep;
                MSep:    st_d = is_digit(ch) ? MDig : MDead;
                MDead:   st_d = MDead;
                default: st_d = MDead;
            endcase
        end
    end

    assign accept = (st_q == MDig);

endmodule

// File: rtl/string_arbiter.sv
// Round-robin sharing of one digit/separator matcher between two character streams,
// one whole string per grant, reporting verdict, source and length.
module string_arbiter
    import string_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [7:0]       s0_char,
    input  logic             s0_valid,
    input  logic             s0_last,
    output logic             s0_ready,
    input  logic [7:0]       s1_char,
    input  logic             s1_valid,
    input  logic             s1_last,
    output logic             s1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_match,
    output logic             res_src,
    output logic [LEN_W-1:0] res_len,
    output logic             res_ovf
);

    ctl_state_e       state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             rr_q, rr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    logic             cur_valid, cur_last, acc, m_accept;
    logic [7:0]       cur_char;

    assign cur_valid = gnt_q ? s1_valid : s0_valid;
    assign cur_last  = gnt_q ? s1_last  : s0_last;
    assign cur_char  = gnt_q ? s1_char  : s0_char;
    assign acc       = cur_valid && (state_q == StStream);

    digit_alt_matcher u_matcher (
        .clk    (clk),
        .clr_n  (clr_n),
        .clear  (state_q == StClear),
        .step   (acc),
        .ch     (cur_char),
        .accept (m_accept)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if (s0_valid || s1_valid) begin
                    state_d = StClear;
                    gnt_d   = (s0_valid && s1_valid) ? rr_q : s1_valid;
                    rr_d    = ~gnt_d;
                end
            end
            StClear:  state_d = StStream;
            StStream: if (acc && cur_last) state_d = StReport;
            StReport: if (res_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Length saturates at MAX_LEN; any further accept marks the string as overflowed.
    always_comb begin
        len_d = len_q;
        ovf_d = ovf_q;
        if (state_q == StClear) begin
            len_d = '0;
            ovf_d = 1'b0;
        end else if (acc) begin
            if (len_q == LEN_W'(MAX_LEN)) begin
                ovf_d = 1'b1;
            end else begin
                len_d = len_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            len_q <= len_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        s0_ready  = (state_q == StStream) && !gnt_q;
        s1_ready  = (state_q == StStream) && gnt_q;
        res_valid = (state_q == StReport);
        res_match = res_valid && m_accept && !ovf_q;
        res_src   = res_valid && gnt_q;
        res_len   = res_valid ? len_q : '0;
        res_ovf   = res_valid && ovf_q;
    end

endmodule

// File: tb/tb_string_arbiter.sv
// Directed bench for string_arbiter, built with MAX_LEN=4 so overflow is reachable.
module tb_string_arbiter;

    localparam int unsigned MaxLen = 4;
    localparam int unsigned LenW   = 3;

    logic            clk = 1'b0;
    logic            clr_n;
    logic [7:0]      s0_char, s1_char;
    logic            s0_valid, s0_last, s0_ready;
    logic            s1_valid, s1_last, s1_ready;
    logic            res_valid, res_ready, res_match, res_src, res_ovf;
    logic [LenW-1:0] res_len;

    int n_tests = 0;
    int n_fail  = 0;
    int both_rdy = 0;

    logic r_m;
    int   r_src, r_len;
    logic r_ovf;
    int   q_src[4];
    int   q_len[4];
    int   q_m[4];

    always #5 clk = ~clk;

    string_arbiter #(.MAX_LEN(MaxLen), .LEN_W(LenW)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .s0_char   (s0_char),
        .s0_valid  (s0_valid),
        .s0_last   (s0_last),
        .s0_ready  (s0_ready),
        .s1_char   (s1_char),
        .s1_valid  (s1_valid),
        .s1_last   (s1_last),
        .s1_ready  (s1_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_match (res_match),
        .res_src   (res_src),
        .res_len   (res_len),
        .res_ovf   (res_ovf)
    );

    always @(negedge clk) if (s0_ready && s1_ready) both_rdy++;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int src);
        return (src == 1) ? s1_ready : s0_ready;
    endfunction

    task automatic drive(input int src, input logic v, input logic [7:0] c, input logic l);
        if (src == 1) begin
            s1_valid = v; s1_char = c; s1_last = l;
        end else begin
            s0_valid = v; s0_char = c; s0_last = l;
        end
    endtask

    // Sends the first n chars of s, handshaking each at negedge; last marks the final char of s.
    task automatic send_str(input int src, input string s, input int n);
        int waited;
        for (int i = 0; i < n; i++) begin
            drive(src, 1'b1, s[i], (i == s.len() - 1));
            waited = 0;
            while (!rdy(src) && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            if (!rdy(src)) begin
                check({"ready_timeout ", s}, int'(rdy(src)), 1);
                drive(src, 1'b0, 8'h00, 1'b0);
                return;
            end
            @(negedge clk);
        end
        drive(src, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic get_result(output logic m, output int src, output int len, output logic ovf);
        int waited = 0;
        while (!res_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("res_valid_timeout", int'(res_valid), 1);
        m   = res_match;
        src = int'(res_src);
        len = int'(res_len);
        ovf = res_ovf;
        @(negedge clk);
    endtask

    task automatic run_str(input int src, input string s, input int em, input int el,
                           input int eo);
        logic m, o;
        int   rs, rl;
        send_str(src, s, s.len());
        get_result(m, rs, rl, o);
        check({s, " match"}, int'(m), em);
        check({s, " src"}, rs, src);
        check({s, " len"}, rl, el);
        check({s, " ovf"}, int'(o), eo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

    initial begin
        int seen;
        clr_n = 1'b0;
        res_ready = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("rst res_valid", int'(res_valid), 0);
        check("rst s0_ready", int'(s0_ready), 0);
        check("rst s1_ready", int'(s1_ready), 0);
        check("rst res_len", int'(res_len), 0);
        check("rst res_match", int'(res_match), 0);
        clr_n = 1'b1;
        @(negedge clk);

        // T1: result valid the cycle after the single char is accepted
        send_str(0, "1", 1);
        check("T1 res_valid", int'(res_valid), 1);
        check("T1 match", int'(res_match), 1);
        check("T1 src", int'(res_src), 0);
        check("T1 len", int'(res_len), 1);
        check("T1 ovf", int'(res_ovf), 0);
        @(negedge clk);
        check("T1 res_valid drop", int'(res_valid), 0);

        // T2
        run_str(0, "1a2", 1, 3, 0);
        run_str(0, "12", 0, 2, 0);
        run_str(0, "1a", 0, 2, 0);
        run_str(0, "a", 0, 1, 0);

        // T3: fresh reset, both requesters compete; grants alternate starting with 0
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        both_rdy = 0;
        fork
            begin
                send_str(0, "1", 1);
                send_str(0, "12", 2);
            end
            begin
                send_str(1, "3a4", 3);
                send_str(1, "x", 1);
            end
            begin
                for (int r = 0; r < 4; r++) begin
                    get_result(r_m, r_src, r_len, r_ovf);
                    q_src[r] = r_src;
                    q_len[r] = r_len;
                    q_m[r]   = int'(r_m);
                end
            end
        join
        check("T3 src0", q_src[0], 0);
        check("T3 src1", q_src[1], 1);
        check("T3 src2", q_src[2], 0);
        check("T3 src3", q_src[3], 1);
        check("T3 len0", q_len[0], 1);
        check("T3 len1", q_len[1], 3);
        check("T3 len2", q_len[2], 2);
        check("T3 len3", q_len[3], 1);
        check("T3 m0", q_m[0], 1);
        check("T3 m1", q_m[1], 1);
        check("T3 m2", q_m[2], 0);
        check("T3 m3", q_m[3], 0);
        check("T3 both_ready", both_rdy, 0);

        // T4: consumer stalls for 5 REPORT cycles while s1 is already requesting
        res_ready = 1'b0;
        send_str(0, "7", 1);
        drive(1, 1'b1, 8'h35, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("T4 hold valid", int'(res_valid), 1);
            check("T4 hold match", int'(res_match), 1);
            check("T4 hold src", int'(res_src), 0);
            check("T4 hold len", int'(res_len), 1);
            check("T4 hold s0_ready", int'(s0_ready), 0);
            check("T4 hold s1_ready", int'(s1_ready), 0);
            @(negedge clk);
        end
        check("T4 6th valid", int'(res_valid), 1);
        res_ready = 1'b1;
        @(negedge clk);
        check("T4 released", int'(res_valid), 0);
        seen = 0;
        while (!s1_ready && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        check("T4 s1 granted", int'(s1_ready), 1);
        @(negedge clk);
        drive(1, 1'b0, 8'h00, 1'b0);
        get_result(r_m, r_src, r_len, r_ovf);
        check("T4 s1 src", r_src, 1);
        check("T4 s1 match", int'(r_m), 1);
        check("T4 s1 len", r_len, 1);

        // T5: exactly MAX_LEN, then one past it
        run_str(1, "1a2b", 0, 4, 0);
        run_str(1, "1a2b3", 0, 4, 1);
        run_str(1, "9", 1, 1, 0);

        // T6: reset in the middle of "1a2" kills it without a result
        send_str(0, "1a2", 2);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("T6 no result", seen, 0);
        run_str(0, "1", 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
